cpu_stage_seq: RTL

- Multi-cycle stage sequencer for the 5-cycle CPU.
- Asserts exactly one stage enable per cycle for fetch, decode, execute, memory and writeback, in program order.
- Skips the memory stage for non-memory opcodes and stalls on a memory-busy handshake.
- Stops permanently on the halt opcode 6'b111111; sits between the top level and the five stage modules.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cpu_stage_seq_if.sv | 39 +++
 rtl/cpu_mem_watchdog.sv | 36 +++
 rtl/cpu_stage_seq.sv | 113 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-cycle CPU stage sequencer.
// This file covers the opcode constants, the MEM timeout limit, the sequencer state set,
// and the memory-opcode helper.
package cpu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_HALT = 6'b111111;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

    // Number of consecutive busy MEM cycles tolerated; the last one trips the fault.
    localparam int MEM_TMO = 16;
    localparam int TMO_W   = $clog2(MEM_TMO) + 1;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    // Loads and stores are the only instructions that visit the MEM stage.
    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/cpu_stage_seq_if.sv
// Interface between the CPU top level (master) and the stage sequencer (slave).
// The interface carries the opcode/mem_busy inputs and all stage enables and status flags.
// Optional macro CPU_STAGE_SEQ_PERF_EN adds the cyc_cnt/ret_cnt performance counters.
interface cpu_stage_seq_if;
    import cpu_pkg::*;

    logic [OP_W-1:0] opcode;
    logic            mem_busy;
    logic            fetch_en;
    logic            dec_en;
    logic            ex_en;
    logic            mem_en;
    logic            wb_en;
    logic            reg_we;
    logic            pc_we;
    logic            halted;
    logic            fault;
`ifdef CPU_STAGE_SEQ_PERF_EN
    logic [31:0]     cyc_cnt;
    logic [31:0]     ret_cnt;
`endif

    modport master (
        output opcode, mem_busy,
        input  fetch_en, dec_en, ex_en, mem_en, wb_en, reg_we, pc_we, halted, fault
`ifdef CPU_STAGE_SEQ_PERF_EN
        , input cyc_cnt, ret_cnt
`endif
    );

    modport slave (
        input  opcode, mem_busy,
        output fetch_en, dec_en, ex_en, mem_en, wb_en, reg_we, pc_we, halted, fault
`ifdef CPU_STAGE_SEQ_PERF_EN
        , output cyc_cnt, ret_cnt
`endif
    );

endinterface

// File: rtl/cpu_mem_watchdog.sv
// MEM-stage watchdog that counts consecutive busy cycles spent in MEM.
// timeout_o flags the cycle on which the stage has been busy for MEM_TMO cycles in a row.
// The owner holds clear_i high in reset and in every cycle outside MEM.
module cpu_mem_watchdog
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic clear_i,
    input  logic busy_i,
    output logic timeout_o
);

    localparam logic [TMO_W-1:0] CNT_MAX  = '1;
    localparam logic [TMO_W-1:0] CNT_TRIP = TMO_W'(MEM_TMO - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Saturating count of busy cycles since MEM was entered.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (busy_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register; clear_i doubles as the synchronous reset.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign timeout_o = ~clear_i & busy_i & (cnt_q == CNT_TRIP);

endmodule

// File: rtl/cpu_stage_seq.sv
// Multi-cycle stage sequencer for the 5-cycle CPU.
// It issues one stage enable per cycle (F, D, E, [M], W), skips MEM for non-memory ops,
// stalls on mem_busy, and stops for good on the halt opcode or on a MEM timeout.
// Optional macro CPU_STAGE_SEQ_PERF_EN adds cycle and retired-instruction counters.
//
// state  | meaning
// RST    | held in reset, all outputs low
// FETCH  | fetch stage enabled
// DECODE | decode stage enabled, opcode latched
// EXEC   | execute stage enabled
// MEM    | memory stage enabled, stalls while mem_busy
// WB     | writeback, PC update, register write unless store
// HALT   | halt opcode seen, absorbing
// FAULT  | memory stage timed out, absorbing
module cpu_stage_seq
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    cpu_stage_seq_if.slave bus
);

    state_e          state_q;
    state_e          state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] op_d;
    logic            wdg_clear;
    logic            wdg_timeout;

    assign wdg_clear = clr | (state_q != ST_MEM);

    cpu_mem_watchdog u_wdg (
        .clk       (clk),
        .clear_i   (wdg_clear),
        .busy_i    (bus.mem_busy),
        .timeout_o (wdg_timeout)
    );

    // Next-state and opcode latch; opcode is captured only in DECODE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                op_d    = bus.opcode;
                state_d = (bus.opcode == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC:   state_d = is_mem_op(op_q) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (wdg_timeout) begin
                    state_d = ST_FAULT;
                end else if (!bus.mem_busy) begin
                    state_d = ST_WB;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_RST;
        endcase
    end

    // State and opcode registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RST;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Outputs decode only registered state and opcode, so nothing passes straight from inputs.
    assign bus.fetch_en = (state_q == ST_FETCH);
    assign bus.dec_en   = (state_q == ST_DECODE);
    assign bus.ex_en    = (state_q == ST_EXEC);
    assign bus.mem_en   = (state_q == ST_MEM);
    assign bus.wb_en    = (state_q == ST_WB);
    assign bus.pc_we    = (state_q == ST_WB);
    assign bus.reg_we   = (state_q == ST_WB) && (op_q != OP_SW);
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.fault    = (state_q == ST_FAULT);

`ifdef CPU_STAGE_SEQ_PERF_EN
    logic [31:0] cyc_cnt_q;
    logic [31:0] ret_cnt_q;
    logic        active;

    assign active = (state_q != ST_RST) && (state_q != ST_HALT) && (state_q != ST_FAULT);

    // Wrapping cycle and retirement counters.
    always_ff @(posedge clk) begin
        if (clr) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            if (active) begin
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end
            if (state_q == ST_WB) begin
                ret_cnt_q <= ret_cnt_q + 32'd1;
            end
        end
    end

    assign bus.cyc_cnt = cyc_cnt_q;
    assign bus.ret_cnt = ret_cnt_q;
`endif

endmodule
